seg7_score_scanner: RTL

Parametrised multiplexed 7-segment driver for the board's 8-digit common display. It accepts an unsigned binary score of configurable width and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes up to 8 digits onto SEG_COM/SEG_DATA. Over a fixed-format score printer it adds leading-zero blanking, overflow indication, blink mode, per-digit decimal points and a one-entry pending-load buffer.

---
 rtl/seg7_score_scanner.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_score_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg7_score_scanner
// Purpose  : Multiplexed 8-digit common 7-segment driver for a binary score.
//            The score is converted to BCD by a sequential double-dabble
//            engine, then scanned one digit at a time with leading-zero
//            blanking, overflow dashes, blink and per-digit decimal points.
//            A one-entry pending buffer holds a load that arrives while a
//            conversion is running (latest load wins).
// Ports    : clk      - system clock, rising edge
//            nRST     - asynchronous active-low reset
//            value    - unsigned score (DATA_W bits), captured on load
//            load     - single-cycle capture request
//            blank_lz - 1 = blank leading zeros
//            blink_en - 1 = blink the whole display
//            dp_mask  - bit k lights the decimal point of digit k
//            SEG_COM  - digit enables, active-low, bit 0 = rightmost digit
//            SEG_DATA - segments {a,b,c,d,e,f,g,dp}, active-high
//            busy     - conversion in progress
//            overflow - last committed value >= 10^N_DIGITS
// Revision : 1.0 - initial release
// ============================================================================
module seg7_score_scanner #(
    parameter int DATA_W       = 14,
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 10000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic              blank_lz,
    input  logic              blink_en,
    input  logic [7:0]        dp_mask,
    output logic [7:0]        SEG_COM,
    output logic [7:0]        SEG_DATA,
    output logic              busy,
    output logic              overflow
);

    // Decimal digits needed to hold 2^w - 1.
    function automatic int bcd_digits_f(input int w);
        longint m;
        int     n;
        m = (longint'(1) << w) - 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m != 0) begin
                n++;
                m = m / 10;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic longint pow10_f(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_code_f(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    localparam int          BCD_DIGITS = bcd_digits_f(DATA_W);
    localparam int          BCD_W      = 4 * BCD_DIGITS;
    localparam int          CNT_W      = $clog2(DATA_W + 1);
    localparam int          DIV_W      = $clog2(SCAN_DIV);
    localparam int          FRM_W      = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(N_DIGITS - 1);
    localparam logic [63:0]      OVF_LIMIT = 64'(pow10_f(N_DIGITS));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Conversion state
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   bin_q, bin_d;      // shifts out MSB-first
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DATA_W-1:0]   cap_q, cap_d;      // unshifted copy for overflow test
    logic [DATA_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [31:0]         disp_q, disp_d;
    logic                ovf_q, ovf_d;
    // Scan / blink state
    logic [DIV_W-1:0]    div_q, div_d;
    logic [2:0]          idx_q, idx_d;
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic                phase_q, phase_d;  // 1 = on phase
    logic [7:0]          com_q, com_d;
    logic [7:0]          seg_q, seg_d;

    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_bcd_step;
    logic [31:0]         w_bcd32;
    logic                w_frame;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift.
    always_comb begin
        w_adj = bcd_q;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        w_bcd_step = {w_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    // Fit the BCD result into the 8-digit display register.
    generate
        if (BCD_W >= 32) begin : g_disp_trunc
            assign w_bcd32 = bcd_q[31:0];
        end else begin : g_disp_ext
            assign w_bcd32 = {{(32-BCD_W){1'b0}}, bcd_q};
        end
    endgenerate

    // Conversion FSM and pending buffer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cap_d      = cap_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    cap_d   = value;
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = w_bcd_step;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = COMMIT;
                if (load) begin
                    pend_d     = value;
                    pend_vld_d = 1'b1;
                end
            end
            COMMIT: begin
                disp_d = w_bcd32;
                ovf_d  = (64'(cap_q) >= OVF_LIMIT);
                // A load in this very cycle beats the pending entry.
                if (load || pend_vld_q) begin
                    cap_d      = load ? value : pend_q;
                    bin_d      = load ? value : pend_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan and blink phase
    always_comb begin
        div_d   = div_q + 1'b1;
        idx_d   = idx_q;
        w_frame = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d   = 3'd0;
                w_frame = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
        frm_d   = frm_q;
        phase_d = phase_q;
        if (!blink_en) begin
            frm_d   = '0;
            phase_d = 1'b1;
        end else if (w_frame) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Registered segment / common outputs for the active digit
    always_comb begin
        logic [7:0] blank;
        logic       acc;
        logic [7:0] code;
        // blank[k]: digit k and every digit above it are zero
        blank = '0;
        acc   = blank_lz;
        for (int k = 7; k >= 1; k--) begin
            if (k < N_DIGITS) begin
                acc      = acc & (disp_q[4*k +: 4] == 4'd0);
                blank[k] = acc;
            end
        end
        if (ovf_q)             code = 8'h02;
        else if (blank[idx_q]) code = 8'h00;
        else                   code = seg_code_f(disp_q[{idx_q, 2'b00} +: 4]);
        // blink_en low overrides a stale off phase immediately
        if (phase_q || !blink_en) begin
            com_d = ~(8'd1 << idx_q);
            seg_d = code | {7'd0, dp_mask[idx_q]};
        end else begin
            com_d = 8'hFF;
            seg_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cap_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            div_q      <= '0;
            idx_q      <= 3'd0;
            frm_q      <= '0;
            phase_q    <= 1'b1;
            com_q      <= 8'hFF;
            seg_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cap_q      <= cap_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            frm_q      <= frm_d;
            phase_q    <= phase_d;
            com_q      <= com_d;
            seg_q      <= seg_d;
        end
    end

    assign SEG_COM  = com_q;
    assign SEG_DATA = seg_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule
`default_nettype wire
